lb_row_sched: RTL and testbench
===============================

Name: lb_row_sched

Overview:
- Row scheduler for the 3x3 convolution stage's three line buffers.
- Fetches image rows from the row-wide image memory and primes the buffers with rows 0..2.
- After each completed convolution pass, overwrites the oldest buffer with the next row, rotating the buffers round-robin.
- Drives each buffer's row-data bus and one-hot write enable; consumes the conv stage's output_valid as its per-pass completion pulse.

Parameters:
ROW_BITS, 800, width of one image row (100 pixels x 8 bits)
NUM_ROWS, 28, image rows per frame; must be >= 3
ADDR_W, 10, image memory row-address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  frame start pulse; sampled only in IDLE
img_base  input  ADDR_W  row address of frame row 0; captured on accepted start
mem_rd_en  output  1  image memory read strobe
mem_addr  output  ADDR_W  image memory row address
mem_rd_data  input  ROW_BITS  memory read data, valid exactly 1 cycle after mem_rd_en
ram1  output  ROW_BITS  row data to line buffer 0
ram2  output  ROW_BITS  row data to line buffer 1
ram3  output  ROW_BITS  row data to line buffer 2
wr_en  output  3  one-hot line-buffer write pulse; bit i writes buffer i
conv_done  input  1  conv pass complete (conv output_valid), one-cycle pulse
row_sel  output  2  index of the buffer holding the oldest row (top of window)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at frame end
err  output  1  sticky protocol error

Behaviour:
- Reset values: all outputs 0, ram1..3 = 0, state IDLE. Counters cleared.
- Reset has priority over every other event, including mid-fetch. Any in-flight read is abandoned. There is no wr_en pulse after reset.
- States: IDLE, RD, CAP, WR, WAIT, DONE.
- IDLE:
  - On start=1: capture img_base, clear row counter (next_row=0), pass counter, slot=0 and err. Set busy=1. Go to RD.
- RD (1 cycle):
  - mem_rd_en=1.
  - mem_addr = img_base + next_row, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
- CAP (1 cycle): register mem_rd_data into ram[slot].
- WR (1 cycle):
  - wr_en = 1<<slot.
  - ram[slot] stays stable this cycle and holds until that slot is next written.
  - Then next_row++ and slot = (slot+1) mod 3.
  - If next_row (after increment) < 3: go to RD (priming). Otherwise go to WAIT.
- Row load timing: one row load takes 3 cycles. With start sampled at cycle 0, priming wr_en pulses are 001 @3, 010 @6, 100 @9. WAIT is entered at cycle 10.
- row_sel:
  - Equals slot; 0 after priming.
  - After each steady-state load it equals the freshly advanced slot, i.e. the buffer now holding the oldest row.
- WAIT, on conv_done:
  - pass++.
  - If pass (after increment) == NUM_ROWS-2: go to DONE.
  - Else go to RD, loading row next_row into ram[slot]. The RD cycle is the cycle after the conv_done sample.
- DONE: done=1 for one cycle; busy=0 from the next cycle; return to IDLE.
- Totals: exactly NUM_ROWS wr_en pulses and NUM_ROWS-2 conv passes per frame.
- conv_done outside WAIT (RD/CAP/WR/IDLE/DONE): ignored for sequencing; sets err=1. err is cleared only by reset or an accepted start.
- start while busy: ignored, no error.
- Simultaneous conv_done and start in IDLE: start accepted; conv_done sets err, then the start clears err. Net result: err=0, start wins.
- wr_en is never multi-hot; at most one write pulse every 3 cycles.

Test Plan:
1. NUM_ROWS=5, img_base=0, mem row r = 100 bytes of value r+1; start at cycle 0 -> mem_addr 0,1,2 at cycles 1,4,7; wr_en 001@3, 010@6, 100@9; ram1=all 0x01, ram2=0x02, ram3=0x03; row_sel=0; busy=1.
2. Continue test 1 with conv_done pulses in WAIT:
   - 1st pulse -> row 3 loaded with wr_en=001, ram1=all 0x04, row_sel=1.
   - 2nd pulse -> wr_en=010, ram2=0x05, row_sel=2.
   - 3rd pulse -> done pulse, no further wr_en, busy=0; 5 wr_en pulses total.
3. ADDR_W=10, img_base=1022, NUM_ROWS=3 -> mem_addr 1022, 1023, 0; one conv_done -> done.
4. conv_done at cycle 5 (mid-priming) -> sequencing unchanged (wr_en 010@6), err=1 and held; next start -> err=0.
5. rst asserted during CAP of row 3 -> next cycle all outputs 0, state IDLE; new start reloads rows 0..2 from img_base with the cycle-3/6/9 timing.
6. start pulses at cycles 2 and 11 during a busy frame -> ignored, timing identical to test 1, err stays 0.

Source files
------------

// File: rtl/lb_row_sched.sv
// Row scheduler for the three 3x3-convolution line buffers: primes rows 0..2, then
// replaces the oldest buffer with the next image row after every completed conv pass.
module lb_row_sched #(
    parameter int unsigned ROW_BITS = 800,
    parameter int unsigned NUM_ROWS = 28,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_img_base,
    output logic                o_mem_rd_en,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic [ROW_BITS-1:0] i_mem_rd_data,
    output logic [ROW_BITS-1:0] o_ram1,
    output logic [ROW_BITS-1:0] o_ram2,
    output logic [ROW_BITS-1:0] o_ram3,
    output logic [2:0]          o_wr_en,
    input  logic                i_conv_done,
    output logic [1:0]          o_row_sel,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int unsigned CNT_W = $clog2(NUM_ROWS + 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRd   = 3'd1;
    localparam logic [2:0] StCap  = 3'd2;
    localparam logic [2:0] StWr   = 3'd3;
    localparam logic [2:0] StWait = 3'd4;
    localparam logic [2:0] StDone = 3'd5;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_next_row;
    logic [CNT_W-1:0]    r_pass;
    logic [1:0]          r_slot;
    logic                r_err;
    logic [ROW_BITS-1:0] r_ram1;
    logic [ROW_BITS-1:0] r_ram2;
    logic [ROW_BITS-1:0] r_ram3;

    logic [2:0]          w_state_nxt;
    logic [ADDR_W-1:0]   w_base_nxt;
    logic [CNT_W-1:0]    w_next_row_nxt;
    logic [CNT_W-1:0]    w_pass_nxt;
    logic [1:0]          w_slot_nxt;
    logic                w_err_nxt;
    logic [ADDR_W-1:0]   w_row_off;

    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_next_row_nxt = r_next_row;
        w_pass_nxt     = r_pass;
        w_slot_nxt     = r_slot;
        w_err_nxt      = r_err;

        // A completion pulse is only meaningful while waiting on the conv stage.
        if (i_conv_done && (r_state != StWait)) begin
            w_err_nxt = 1'b1;
        end

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt    = StRd;
                    w_base_nxt     = i_img_base;
                    w_next_row_nxt = '0;
                    w_pass_nxt     = '0;
                    w_slot_nxt     = 2'd0;
                    w_err_nxt      = 1'b0;
                end
            end
            StRd:   w_state_nxt = StCap;
            StCap:  w_state_nxt = StWr;
            StWr: begin
                w_next_row_nxt = r_next_row + 1'b1;
                w_slot_nxt     = (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
                w_state_nxt    = (r_next_row < CNT_W'(2)) ? StRd : StWait;
            end
            StWait: begin
                if (i_conv_done) begin
                    w_pass_nxt  = r_pass + 1'b1;
                    w_state_nxt = (r_pass == CNT_W'(NUM_ROWS - 3)) ? StDone : StRd;
                end
            end
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_base     <= '0;
            r_next_row <= '0;
            r_pass     <= '0;
            r_slot     <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_base     <= w_base_nxt;
            r_next_row <= w_next_row_nxt;
            r_pass     <= w_pass_nxt;
            r_slot     <= w_slot_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Memory data arrives the cycle after the read strobe, i.e. during CAP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ram1 <= '0;
            r_ram2 <= '0;
            r_ram3 <= '0;
        end else if (r_state == StCap) begin
            case (r_slot)
                2'd0:    r_ram1 <= i_mem_rd_data;
                2'd1:    r_ram2 <= i_mem_rd_data;
                2'd2:    r_ram3 <= i_mem_rd_data;
                default: ;
            endcase
        end
    end

    assign w_row_off   = ADDR_W'(r_next_row);
    assign o_mem_rd_en = (r_state == StRd);
    assign o_mem_addr  = o_mem_rd_en ? (r_base + w_row_off) : '0;
    assign o_wr_en     = (r_state == StWr) ? (3'b001 << r_slot) : 3'b000;
    assign o_row_sel   = r_slot;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_err       = r_err;
    assign o_ram1      = r_ram1;
    assign o_ram2      = r_ram2;
    assign o_ram3      = r_ram3;

endmodule

// File: tb/tb_lb_row_sched.sv
// Bench for lb_row_sched: a 5-row instance for the main frame scenarios and a 3-row
// instance for address wrap; memory reads and buffer writes are scored against queues.
module tb_lb_row_sched;

    localparam int unsigned RB = 800;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start5, start3, conv5, conv3;
    logic [AW-1:0] base5, base3;

    logic          rd_en5, rd_en3, busy5, busy3, done5, done3, err5, err3;
    logic [AW-1:0] addr5, addr3;
    logic [RB-1:0] rdata5, rdata3;
    logic [RB-1:0] ram1_5, ram2_5, ram3_5, ram1_3, ram2_3, ram3_3;
    logic [2:0]    wr5, wr3;
    logic [1:0]    row_sel5, row_sel3;

    lb_row_sched #(.ROW_BITS(RB), .NUM_ROWS(5), .ADDR_W(AW)) u_dut5 (
        .i_clk(clk), .i_rst(rst), .i_start(start5), .i_img_base(base5),
        .o_mem_rd_en(rd_en5), .o_mem_addr(addr5), .i_mem_rd_data(rdata5),
        .o_ram1(ram1_5), .o_ram2(ram2_5), .o_ram3(ram3_5), .o_wr_en(wr5),
        .i_conv_done(conv5), .o_row_sel(row_sel5), .o_busy(busy5), .o_done(done5),
        .o_err(err5)
    );

    lb_row_sched #(.ROW_BITS(RB), .NUM_ROWS(3), .ADDR_W(AW)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .i_img_base(base3),
        .o_mem_rd_en(rd_en3), .o_mem_addr(addr3), .i_mem_rd_data(rdata3),
        .o_ram1(ram1_3), .o_ram2(ram2_3), .o_ram3(ram3_3), .o_wr_en(wr3),
        .i_conv_done(conv3), .o_row_sel(row_sel3), .o_busy(busy3), .o_done(done3),
        .o_err(err3)
    );

    // Image memory: every byte of the row at address a holds a+1; garbage when not read.
    logic [7:0] b5, b3;
    assign b5 = addr5[7:0] + 8'd1;
    assign b3 = addr3[7:0] + 8'd1;
    always @(posedge clk) begin
        rdata5 <= rd_en5 ? {100{b5}} : {100{8'hA5}};
        rdata3 <= rd_en3 ? {100{b3}} : {100{8'hA5}};
    end

    // Monitor looks at one instance at a time.
    logic          mon3;
    logic          m_rd_en, m_busy, m_done, m_err;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_wr;
    logic [1:0]    m_row_sel;
    logic [RB-1:0] m_ram1, m_ram2, m_ram3;
    assign m_rd_en   = mon3 ? rd_en3   : rd_en5;
    assign m_busy    = mon3 ? busy3    : busy5;
    assign m_done    = mon3 ? done3    : done5;
    assign m_err     = mon3 ? err3     : err5;
    assign m_addr    = mon3 ? addr3    : addr5;
    assign m_wr      = mon3 ? wr3      : wr5;
    assign m_row_sel = mon3 ? row_sel3 : row_sel5;
    assign m_ram1    = mon3 ? ram1_3   : ram1_5;
    assign m_ram2    = mon3 ? ram2_3   : ram2_5;
    assign m_ram3    = mon3 ? ram3_3   : ram3_5;

    typedef struct { int cyc; logic [AW-1:0] addr; } rd_exp_t;
    typedef struct { int cyc; logic [2:0] wr; logic [7:0] b; } wr_exp_t;
    typedef struct { int rel; logic [2:0] wr; int row; } prime_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    prime_t  prime_tbl[3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int c0     = 0;
    int nwr    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - c0);
        end
    endtask

    task automatic chk_row(input string name, input logic [RB-1:0] act, input logic [7:0] b);
        logic [RB-1:0] e;
        e = {100{b}};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected all bytes %h", name, act, b);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] base, input int row);
        logic [AW-1:0] a;
        a = base + AW'(row);
        return a[7:0] + 8'd1;
    endfunction

    // Advance to the next falling edge and score any read or write seen there.
    task automatic tick();
        rd_exp_t       re;
        wr_exp_t       we;
        logic [RB-1:0] row;
        @(negedge clk);
        if (m_rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", m_rd_en, 0);
            else begin
                re = rd_q.pop_front();
                chk("rd_cycle", cyc - c0, re.cyc - c0);
                chk("rd_addr", m_addr, re.addr);
            end
        end
        if (m_wr != 3'b000) begin
            nwr++;
            if (wr_q.size() == 0) chk("wr_unexpected", m_wr, 0);
            else begin
                we = wr_q.pop_front();
                chk("wr_cycle", cyc - c0, we.cyc - c0);
                chk("wr_onehot", m_wr, we.wr);
                row = (we.wr == 3'b010) ? m_ram2 : (we.wr == 3'b100) ? m_ram3 : m_ram1;
                chk_row("wr_row", row, we.b);
            end
        end
    endtask

    task automatic push_load(input int rd_abs, input logic [2:0] wr, input int row,
                             input logic [AW-1:0] base);
        rd_exp_t re;
        wr_exp_t we;
        re.cyc  = rd_abs;
        re.addr = base + AW'(row);
        we.cyc  = rd_abs + 2;
        we.wr   = wr;
        we.b    = exp_byte(base, row);
        rd_q.push_back(re);
        wr_q.push_back(we);
    endtask

    task automatic wait_rel(input int k);
        while (cyc - c0 < k) tick();
    endtask

    task automatic set_start(input logic v);
        if (mon3) start3 = v; else start5 = v;
    endtask

    task automatic set_conv(input logic v);
        if (mon3) conv3 = v; else conv5 = v;
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input logic with_conv);
        c0  = cyc;
        nwr = 0;
        if (mon3) base3 = base; else base5 = base;
        set_start(1'b1);
        set_conv(with_conv);
        for (int i = 0; i < 3; i++)
            push_load(c0 + prime_tbl[i].rel - 2, prime_tbl[i].wr, prime_tbl[i].row, base);
        tick();
        set_start(1'b0);
        set_conv(1'b0);
    endtask

    task automatic pulse_conv(input int rel);
        wait_rel(rel);
        set_conv(1'b1);
        tick();
        set_conv(1'b0);
    endtask

    task automatic prime_checks(input logic exp_err, input logic [AW-1:0] base);
        wait_rel(10);
        chk("prime_busy", m_busy, 1);
        chk("prime_row_sel", m_row_sel, 0);
        chk("prime_wr_idle", m_wr, 0);
        chk("prime_rd_idle", m_rd_en, 0);
        chk("prime_done", m_done, 0);
        chk("prime_err", m_err, exp_err);
        chk("prime_nwr", nwr, 3);
        chk_row("prime_ram1", m_ram1, exp_byte(base, 0));
        chk_row("prime_ram2", m_ram2, exp_byte(base, 1));
        chk_row("prime_ram3", m_ram3, exp_byte(base, 2));
    endtask

    // Steady-state passes of the 5-row frame after priming.
    task automatic tail(input logic exp_err, input logic [AW-1:0] base);
        wait_rel(12);
        push_load(c0 + 13, 3'b001, 3, base);
        pulse_conv(12);
        wait_rel(16);
        chk("pass1_row_sel", m_row_sel, 1);
        chk_row("pass1_ram1", m_ram1, exp_byte(base, 3));
        chk_row("pass1_ram2_held", m_ram2, exp_byte(base, 1));
        wait_rel(20);
        push_load(c0 + 21, 3'b010, 4, base);
        pulse_conv(20);
        wait_rel(24);
        chk("pass2_row_sel", m_row_sel, 2);
        chk_row("pass2_ram2", m_ram2, exp_byte(base, 4));
        pulse_conv(26);
        wait_rel(27);
        chk("end_done", m_done, 1);
        chk("end_busy_in_done", m_busy, 1);
        wait_rel(28);
        chk("end_done_cleared", m_done, 0);
        chk("end_busy_cleared", m_busy, 0);
        chk("end_err", m_err, exp_err);
        wait_rel(31);
        chk("end_nwr", nwr, 5);
        chk("end_rd_q_empty", rd_q.size(), 0);
        chk("end_wr_q_empty", wr_q.size(), 0);
    endtask

    initial begin
        rd_exp_t re;
        prime_tbl[0] = '{rel: 3, wr: 3'b001, row: 0};
        prime_tbl[1] = '{rel: 6, wr: 3'b010, row: 1};
        prime_tbl[2] = '{rel: 9, wr: 3'b100, row: 2};
        rst = 1'b1;
        start5 = 1'b0; start3 = 1'b0; conv5 = 1'b0; conv3 = 1'b0;
        base5 = '0; base3 = '0; mon3 = 1'b0;

        repeat (3) tick();
        chk("rst_rd_en", rd_en5, 0);
        chk("rst_addr", addr5, 0);
        chk("rst_wr", wr5, 0);
        chk("rst_row_sel", row_sel5, 0);
        chk("rst_busy", busy5, 0);
        chk("rst_done", done5, 0);
        chk("rst_err", err5, 0);
        chk_row("rst_ram1", ram1_5, 8'h00);
        chk_row("rst_ram3", ram3_5, 8'h00);
        chk("rst3_busy", busy3, 0);
        rst = 1'b0;
        tick();

        // Normal frame, base 0.
        start_frame(10'd0, 1'b0);
        prime_checks(1'b0, 10'd0);
        tail(1'b0, 10'd0);

        // conv_done in IDLE is an error but does not start anything.
        set_conv(1'b1);
        tick();
        set_conv(1'b0);
        chk("idle_conv_err", err5, 1);
        chk("idle_conv_busy", busy5, 0);
        tick();

        // Stray conv_done mid-priming.
        start_frame(10'd0, 1'b0);
        chk("start_clears_err", err5, 0);
        wait_rel(5);
        set_conv(1'b1);
        tick();
        set_conv(1'b0);
        chk("midprime_err", err5, 1);
        prime_checks(1'b1, 10'd0);
        tail(1'b1, 10'd0);

        // start together with conv_done in IDLE, then starts while busy.
        start_frame(10'd0, 1'b1);
        chk("start_wins_err", err5, 0);
        wait_rel(2);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        prime_checks(1'b0, 10'd0);
        wait_rel(11);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        tail(1'b0, 10'd0);

        // Reset during CAP of row 3.
        start_frame(10'd0, 1'b0);
        prime_checks(1'b0, 10'd0);
        wait_rel(12);
        re.cyc  = c0 + 13;
        re.addr = 10'd3;
        rd_q.push_back(re);
        pulse_conv(12);
        wait_rel(14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rd_en", rd_en5, 0);
        chk("midrst_addr", addr5, 0);
        chk("midrst_wr", wr5, 0);
        chk("midrst_row_sel", row_sel5, 0);
        chk("midrst_busy", busy5, 0);
        chk("midrst_done", done5, 0);
        chk_row("midrst_ram1", ram1_5, 8'h00);
        chk_row("midrst_ram2", ram2_5, 8'h00);
        chk("midrst_rd_q_empty", rd_q.size(), 0);
        tick();
        tick();
        chk("midrst_no_wr", nwr, 3);
        start_frame(10'd0, 1'b0);
        prime_checks(1'b0, 10'd0);
        tail(1'b0, 10'd0);

        // 3-row frame with row addresses wrapping past 1023.
        mon3 = 1'b1;
        tick();
        start_frame(10'd1022, 1'b0);
        prime_checks(1'b0, 10'd1022);
        pulse_conv(11);
        wait_rel(12);
        chk("n3_done", done3, 1);
        chk("n3_busy_in_done", busy3, 1);
        wait_rel(13);
        chk("n3_done_cleared", done3, 0);
        chk("n3_busy_cleared", busy3, 0);
        chk("n3_err", err3, 0);
        wait_rel(16);
        chk("n3_nwr", nwr, 3);
        chk("n3_rd_q_empty", rd_q.size(), 0);
        chk("n3_wr_q_empty", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
